// File: rtl/life_gen_sequencer_if.sv
// Control/display bundle between the Life sequencer and the host that loads boards
// and issues commands; the sequencer sits on the slave side.
interface life_gen_sequencer_if #(
    parameter int ROWS   = 16,
    parameter int COLS   = 16,
    parameter int GEN_W  = 16,
    parameter int RATE_W = 24
);
    localparam int RW = $clog2(ROWS);

    logic                   load_valid;
    logic                   load_ready;
    logic [RW-1:0]          load_row;
    logic [COLS-1:0]        load_data;
    logic                   cmd_clear;
    logic                   cmd_step;
    logic                   cmd_run;
    logic [RATE_W-1:0]      rate_div;
    logic [ROWS*COLS-1:0]   board;
    logic [GEN_W-1:0]       gen_count;
    logic                   frame_valid;
    logic                   stable;
    logic                   busy;

    modport master (
        output load_valid, load_row, load_data, cmd_clear, cmd_step, cmd_run, rate_div,
        input  load_ready, board, gen_count, frame_valid, stable, busy
    );

    modport slave (
        input  load_valid, load_row, load_data, cmd_clear, cmd_step, cmd_run, rate_div,
        output load_ready, board, gen_count, frame_valid, stable, busy
    );
endinterface

// File: rtl/life_gen_sequencer.sv
// Game-of-Life generation sequencer: computes one toroidal row per clock into a shadow
// buffer from the committed board, then commits the whole generation in one cycle.
module life_gen_sequencer #(
    parameter int ROWS   = 16,
    parameter int COLS   = 16,
    parameter int GEN_W  = 16,
    parameter int RATE_W = 24
) (
    input  logic                 clk,
    input  logic                 rst_n,
    life_gen_sequencer_if.slave  ctrl
);
    localparam int RW    = $clog2(ROWS);
    localparam int CELLS = ROWS * COLS;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_WAIT    = 2'd1;
    localparam logic [1:0] ST_COMPUTE = 2'd2;
    localparam logic [1:0] ST_COMMIT  = 2'd3;

    localparam logic [RW-1:0] LAST_ROW = RW'(ROWS - 1);
    localparam logic [RW:0]   ROWS_EXT = (RW + 1)'(ROWS);

    logic [1:0]        state_q,  state_d;
    logic [CELLS-1:0]  board_q,  board_d;
    logic [CELLS-1:0]  shadow_q, shadow_d;
    logic [GEN_W-1:0]  gen_q,    gen_d;
    logic              stable_q, stable_d;
    logic              frame_q;
    logic [RW-1:0]     row_q,    row_d;
    logic [RATE_W-1:0] delay_q,  delay_d;

    logic [RW-1:0]     rowUp, rowDn;
    logic [COLS-1:0]   upRow, curRow, dnRow, nextRow;
    logic [3:0]        nbr;

    // Next contents of the current row, read only from the committed board with wrap on both axes.
    always_comb begin
        rowUp   = (row_q == '0) ? LAST_ROW : row_q - RW'(1);
        rowDn   = (row_q == LAST_ROW) ? '0 : row_q + RW'(1);
        upRow   = board_q[int'(rowUp) * COLS +: COLS];
        curRow  = board_q[int'(row_q) * COLS +: COLS];
        dnRow   = board_q[int'(rowDn) * COLS +: COLS];
        nextRow = '0;
        nbr     = '0;
        for (int c = 0; c < COLS; c++) begin
            nbr = 4'(upRow[(c + COLS - 1) % COLS]) + 4'(upRow[c]) + 4'(upRow[(c + 1) % COLS])
                + 4'(curRow[(c + COLS - 1) % COLS]) + 4'(curRow[(c + 1) % COLS])
                + 4'(dnRow[(c + COLS - 1) % COLS]) + 4'(dnRow[c]) + 4'(dnRow[(c + 1) % COLS]);
            nextRow[c] = (nbr == 4'd3) || (curRow[c] && (nbr == 4'd2));
        end
    end

    always_comb begin
        state_d  = state_q;
        board_d  = board_q;
        shadow_d = shadow_q;
        gen_d    = gen_q;
        stable_d = stable_q;
        row_d    = row_q;
        delay_d  = delay_q;
        case (state_q)
            ST_IDLE: begin
                if (ctrl.cmd_clear) begin
                    board_d  = '0;
                    gen_d    = '0;
                    stable_d = 1'b0;
                end else if (ctrl.load_valid) begin
                    if ({1'b0, ctrl.load_row} < ROWS_EXT) begin
                        board_d[int'(ctrl.load_row) * COLS +: COLS] = ctrl.load_data;
                        gen_d    = '0;
                        stable_d = 1'b0;
                    end
                end else if (ctrl.cmd_step) begin
                    state_d = ST_COMPUTE;
                    row_d   = '0;
                end else if (ctrl.cmd_run) begin
                    state_d = ST_WAIT;
                    delay_d = ctrl.rate_div;
                end
            end
            ST_WAIT: begin
                if (delay_q == '0) begin
                    state_d = ST_COMPUTE;
                    row_d   = '0;
                end else begin
                    delay_d = delay_q - RATE_W'(1);
                end
            end
            ST_COMPUTE: begin
                shadow_d[int'(row_q) * COLS +: COLS] = nextRow;
                if (row_q == LAST_ROW) begin
                    state_d = ST_COMMIT;
                end else begin
                    row_d = row_q + RW'(1);
                end
            end
            ST_COMMIT: begin
                // A run already in flight always finishes; cmd_run only decides what follows.
                board_d  = shadow_q;
                stable_d = (shadow_q == board_q);
                gen_d    = gen_q + GEN_W'(1);
                if (ctrl.cmd_run) begin
                    state_d = ST_WAIT;
                    delay_d = ctrl.rate_div;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            board_q  <= '0;
            shadow_q <= '0;
            gen_q    <= '0;
            stable_q <= 1'b0;
            frame_q  <= 1'b0;
            row_q    <= '0;
            delay_q  <= '0;
        end else begin
            state_q  <= state_d;
            board_q  <= board_d;
            shadow_q <= shadow_d;
            gen_q    <= gen_d;
            stable_q <= stable_d;
            frame_q  <= (state_q == ST_COMMIT);
            row_q    <= row_d;
            delay_q  <= delay_d;
        end
    end

    assign ctrl.load_ready  = (state_q == ST_IDLE);
    assign ctrl.busy        = (state_q != ST_IDLE);
    assign ctrl.board       = board_q;
    assign ctrl.gen_count   = gen_q;
    assign ctrl.frame_valid = frame_q;
    assign ctrl.stable      = stable_q;
endmodule

// File: tb/tb_life_gen_sequencer.sv
// Directed bench for life_gen_sequencer: blinker, torus glider, still life, lockout,
// run pacing, mid-compute reset and generation counter wrap (GEN_W=4).
module tb_life_gen_sequencer;
    localparam int ROWS   = 16;
    localparam int COLS   = 16;
    localparam int GEN_W  = 4;
    localparam int RATE_W = 24;
    localparam int CELLS  = ROWS * COLS;
    localparam int RW     = $clog2(ROWS);

    typedef logic [CELLS-1:0] board_t;

    logic clk;
    logic rst_n;
    int   errors;
    int   checks;

    board_t blinkH, blinkV, glider0, glider4, block;

    life_gen_sequencer_if #(.ROWS(ROWS), .COLS(COLS), .GEN_W(GEN_W), .RATE_W(RATE_W)) dut_if();

    life_gen_sequencer #(.ROWS(ROWS), .COLS(COLS), .GEN_W(GEN_W), .RATE_W(RATE_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .ctrl  (dut_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic board_t cellAt(input int r, input int c);
        board_t b;
        b = '0;
        b[r * COLS + c] = 1'b1;
        return b;
    endfunction

    task automatic idleInputs();
        dut_if.load_valid = 1'b0;
        dut_if.load_row   = '0;
        dut_if.load_data  = '0;
        dut_if.cmd_clear  = 1'b0;
        dut_if.cmd_step   = 1'b0;
        dut_if.cmd_run    = 1'b0;
        dut_if.rate_div   = '0;
    endtask

    task automatic loadRow(input int r, input logic [COLS-1:0] d);
        dut_if.load_valid = 1'b1;
        dut_if.load_row   = RW'(r);
        dut_if.load_data  = d;
        @(negedge clk);
        dut_if.load_valid = 1'b0;
    endtask

    task automatic loadBoard(input board_t b);
        logic [COLS-1:0] rowBits;
        dut_if.cmd_clear = 1'b1;
        @(negedge clk);
        dut_if.cmd_clear = 1'b0;
        for (int r = 0; r < ROWS; r++) begin
            rowBits = b[r * COLS +: COLS];
            if (rowBits != '0) loadRow(r, rowBits);
        end
    endtask

    task automatic pulseStep();
        dut_if.cmd_step = 1'b1;
        @(negedge clk);
        dut_if.cmd_step = 1'b0;
    endtask

    // Returns the number of negedges until frame_valid is seen, or -1 on timeout.
    task automatic waitFrame(input int maxCycles, output int n);
        n = -1;
        for (int i = 1; i <= maxCycles; i++) begin
            @(negedge clk);
            if (dut_if.frame_valid === 1'b1) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        idleInputs();
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (dut_if.board !== '0) begin errors++; $display("[TB] FAIL reset_board: got %h expected 0", dut_if.board); end
        checks++; if (dut_if.gen_count !== '0) begin errors++; $display("[TB] FAIL reset_gen: got %0d expected 0", dut_if.gen_count); end
        checks++; if (dut_if.busy !== 1'b0 || dut_if.load_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_busy_ready: got busy=%b ready=%b expected 0/1", dut_if.busy, dut_if.load_ready); end
        checks++; if (dut_if.frame_valid !== 1'b0 || dut_if.stable !== 1'b0) begin errors++; $display("[TB] FAIL reset_flags: got frame=%b stable=%b expected 0/0", dut_if.frame_valid, dut_if.stable); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_blinker();
        int n;
        loadBoard(blinkH);
        checks++; if (dut_if.board !== blinkH) begin errors++; $display("[TB] FAIL blinker_load: got %h expected %h", dut_if.board, blinkH); end
        pulseStep();
        checks++; if (dut_if.busy !== 1'b1 || dut_if.load_ready !== 1'b0) begin errors++; $display("[TB] FAIL blinker_busy: got busy=%b ready=%b expected 1/0", dut_if.busy, dut_if.load_ready); end
        waitFrame(40, n);
        checks++; if (n != ROWS + 1) begin errors++; $display("[TB] FAIL blinker_latency: got %0d expected %0d", n, ROWS + 1); end
        checks++; if (dut_if.board !== blinkV) begin errors++; $display("[TB] FAIL blinker_gen1: got %h expected %h", dut_if.board, blinkV); end
        checks++; if (dut_if.gen_count !== 4'd1 || dut_if.stable !== 1'b0) begin errors++; $display("[TB] FAIL blinker_gen1_count: got gen=%0d stable=%b expected 1/0", dut_if.gen_count, dut_if.stable); end
        @(negedge clk);
        checks++; if (dut_if.frame_valid !== 1'b0 || dut_if.busy !== 1'b0) begin errors++; $display("[TB] FAIL blinker_pulse_width: got frame=%b busy=%b expected 0/0", dut_if.frame_valid, dut_if.busy); end
        pulseStep();
        waitFrame(40, n);
        checks++; if (dut_if.board !== blinkH || dut_if.gen_count !== 4'd2) begin errors++; $display("[TB] FAIL blinker_gen2: got %h gen=%0d expected %h gen=2", dut_if.board, dut_if.gen_count, blinkH); end
    endtask

    task automatic test_still_life();
        int n;
        loadBoard(block);
        pulseStep();
        waitFrame(40, n);
        checks++; if (dut_if.board !== block) begin errors++; $display("[TB] FAIL still_board: got %h expected %h", dut_if.board, block); end
        checks++; if (dut_if.stable !== 1'b1 || dut_if.gen_count !== 4'd1) begin errors++; $display("[TB] FAIL still_stable: got stable=%b gen=%0d expected 1/1", dut_if.stable, dut_if.gen_count); end
    endtask

    task automatic test_busy_lockout();
        int n;
        int readyErr;
        loadBoard(blinkH);
        pulseStep();
        dut_if.load_valid = 1'b1;
        dut_if.load_row   = RW'(7);
        dut_if.load_data  = '1;
        dut_if.cmd_clear  = 1'b1;
        dut_if.cmd_step   = 1'b1;
        readyErr = 0;
        repeat (5) begin
            @(negedge clk);
            if (dut_if.load_ready !== 1'b0) readyErr++;
        end
        idleInputs();
        checks++; if (readyErr != 0) begin errors++; $display("[TB] FAIL lockout_ready: got %0d cycles ready expected 0", readyErr); end
        waitFrame(40, n);
        checks++; if (dut_if.board !== blinkV) begin errors++; $display("[TB] FAIL lockout_board: got %h expected %h", dut_if.board, blinkV); end
        checks++; if (dut_if.gen_count !== 4'd1) begin errors++; $display("[TB] FAIL lockout_gen: got %0d expected 1", dut_if.gen_count); end
    endtask

    task automatic test_torus_glider();
        int n;
        loadBoard(glider0);
        dut_if.rate_div = '0;
        dut_if.cmd_run  = 1'b1;
        waitFrame(60, n);
        for (int g = 2; g <= 3; g++) begin
            waitFrame(60, n);
            checks++; if (n != 18) begin errors++; $display("[TB] FAIL glider_period_%0d: got %0d expected 18", g, n); end
        end
        repeat (3) @(negedge clk);
        dut_if.cmd_run = 1'b0;
        waitFrame(60, n);
        checks++; if (dut_if.board !== glider4) begin errors++; $display("[TB] FAIL glider_shift: got %h expected %h", dut_if.board, glider4); end
        checks++; if (dut_if.gen_count !== 4'd4) begin errors++; $display("[TB] FAIL glider_gen: got %0d expected 4", dut_if.gen_count); end
        @(negedge clk);
        checks++; if (dut_if.busy !== 1'b0) begin errors++; $display("[TB] FAIL glider_stop: got busy=%b expected 0", dut_if.busy); end
    endtask

    task automatic test_run_pacing();
        int n;
        loadBoard(blinkH);
        dut_if.rate_div = RATE_W'(5);
        dut_if.cmd_run  = 1'b1;
        waitFrame(80, n);
        waitFrame(80, n);
        checks++; if (n != 23) begin errors++; $display("[TB] FAIL pacing_period: got %0d expected 23", n); end
        repeat (10) @(negedge clk);
        dut_if.cmd_run = 1'b0;
        checks++; if (dut_if.busy !== 1'b1) begin errors++; $display("[TB] FAIL pacing_midgen_busy: got %b expected 1", dut_if.busy); end
        waitFrame(40, n);
        checks++; if (n != 13) begin errors++; $display("[TB] FAIL pacing_finish: got %0d expected 13", n); end
        checks++; if (dut_if.board !== blinkV || dut_if.gen_count !== 4'd3) begin errors++; $display("[TB] FAIL pacing_final: got %h gen=%0d expected %h gen=3", dut_if.board, dut_if.gen_count, blinkV); end
        @(negedge clk);
        checks++; if (dut_if.busy !== 1'b0) begin errors++; $display("[TB] FAIL pacing_idle: got busy=%b expected 0", dut_if.busy); end
        waitFrame(40, n);
        checks++; if (n != -1) begin errors++; $display("[TB] FAIL pacing_no_restart: got frame after %0d expected none", n); end
        dut_if.rate_div = '0;
    endtask

    task automatic test_reset_midcompute();
        int n;
        loadBoard(blinkH);
        pulseStep();
        waitFrame(40, n);
        pulseStep();
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++; if (dut_if.board !== '0 || dut_if.gen_count !== '0) begin errors++; $display("[TB] FAIL midreset_state: got %h gen=%0d expected 0 gen=0", dut_if.board, dut_if.gen_count); end
        checks++; if (dut_if.busy !== 1'b0 || dut_if.load_ready !== 1'b1) begin errors++; $display("[TB] FAIL midreset_busy: got busy=%b ready=%b expected 0/1", dut_if.busy, dut_if.load_ready); end
        @(negedge clk);
        rst_n = 1'b1;
        waitFrame(30, n);
        checks++; if (n != -1 || dut_if.board !== '0) begin errors++; $display("[TB] FAIL midreset_quiet: got frame=%0d board=%h expected none/0", n, dut_if.board); end
    endtask

    task automatic test_gen_wrap();
        int n;
        loadBoard(blinkH);
        for (int i = 1; i <= 16; i++) begin
            pulseStep();
            waitFrame(40, n);
            if (i == 15) begin
                checks++; if (dut_if.gen_count !== 4'd15) begin errors++; $display("[TB] FAIL wrap_gen15: got %0d expected 15", dut_if.gen_count); end
            end
        end
        checks++; if (dut_if.gen_count !== 4'd0) begin errors++; $display("[TB] FAIL wrap_gen16: got %0d expected 0", dut_if.gen_count); end
        checks++; if (dut_if.board !== blinkH || n != ROWS + 1) begin errors++; $display("[TB] FAIL wrap_board: got %h lat=%0d expected %h lat=%0d", dut_if.board, n, blinkH, ROWS + 1); end
    endtask

    initial begin
        errors  = 0;
        checks  = 0;
        blinkH  = cellAt(7, 6) | cellAt(7, 7) | cellAt(7, 8);
        blinkV  = cellAt(6, 7) | cellAt(7, 7) | cellAt(8, 7);
        glider0 = cellAt(15, 0) | cellAt(0, 1) | cellAt(1, 15) | cellAt(1, 0) | cellAt(1, 1);
        glider4 = cellAt(0, 1) | cellAt(1, 2) | cellAt(2, 0) | cellAt(2, 1) | cellAt(2, 2);
        block   = cellAt(0, 15) | cellAt(0, 0) | cellAt(1, 15) | cellAt(1, 0);
        test_reset();
        test_blinker();
        test_still_life();
        test_busy_lockout();
        test_torus_glider();
        test_run_pacing();
        test_reset_midcompute();
        test_gen_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
